fetch_controller: RTL and testbench

Sequences the instruction fetch stage of the pipelined MIPS core. Owns the PC register, drives the byte address into the instruction memory and captures the returned word into the IF/ID pipeline register. Applies hazard-unit stalls, jump/branch redirects with IF/ID flush, and halts once fetch runs past the loaded program image.

---
 rtl/mips_pkg.sv | 11 +
 rtl/fetch_controller_if.sv | 22 ++
 rtl/fetch_controller_if_id_reg.sv | 29 ++
 rtl/fetch_controller.sv | 78 +++++++
 tb/tb_fetch_controller.sv | 166 ++++++++++++++++
 5 files changed

// File: rtl/mips_pkg.sv
// mips_pkg: shared constants, fetch state encoding and counter helper for the MIPS fetch stage
package mips_pkg;
  localparam int PC_WIDTH = 32;
  localparam logic [31:0] NOP_INSTR = 32'h0;
  localparam logic [5:0] OP_J = 6'h02;
  localparam logic [5:0] OP_BNE = 6'h05;
  typedef enum logic [1:0] {S_INIT, S_RUN, S_HALT} fetch_state_e;
  function automatic logic [15:0] sat_inc(input logic [15:0] v);
    return &v ? v : v + 16'd1;
  endfunction
endpackage

// File: rtl/fetch_controller_if.sv
// fetch_controller_if: instruction-memory, hazard/redirect and IF/ID signals of the fetch stage
interface fetch_controller_if;
  logic [31:0] imem_instr;
  logic        stall;
  logic        jump;
  logic [25:0] jump_index;
  logic        branch_taken;
  logic [31:0] branch_target;
  logic [31:0] imem_pc;
  logic [31:0] ifid_instr;
  logic [31:0] ifid_pc4;
  logic        ifid_valid;
  logic        halted;
  modport master (
    input  imem_instr, stall, jump, jump_index, branch_taken, branch_target,
    output imem_pc, ifid_instr, ifid_pc4, ifid_valid, halted
  );
  modport slave (
    output imem_instr, stall, jump, jump_index, branch_taken, branch_target,
    input  imem_pc, ifid_instr, ifid_pc4, ifid_valid, halted
  );
endinterface

// File: rtl/fetch_controller_if_id_reg.sv
// if_id_reg: IF/ID pipeline register; flush beats load, neither means hold
module if_id_reg
  import mips_pkg::*;
(
  input  logic                clk,
  input  logic                reset,
  input  logic                load,
  input  logic                flush,
  input  logic [31:0]         instr_d,
  input  logic [PC_WIDTH-1:0] pc4_d,
  output logic [31:0]         instr,
  output logic [PC_WIDTH-1:0] pc4,
  output logic                valid
);
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      instr <= NOP_INSTR;
      pc4   <= '0;
      valid <= 1'b0;
    end else if (flush) begin
      instr <= NOP_INSTR;
      valid <= 1'b0;
    end else if (load) begin
      instr <= instr_d;
      pc4   <= pc4_d;
      valid <= 1'b1;
    end
  end
endmodule

// File: rtl/fetch_controller.sv
// fetch_controller: PC, fetch FSM, redirects/stalls and halt past the program image.
// Define FETCH_PERF_EN to add saturating fetch/flush/stall performance counters.
module fetch_controller
  import mips_pkg::*;
#(
  parameter int          MEM_BYTES = 72,
  parameter logic [31:0] RESET_PC  = 32'h0
) (
  input  logic clk,
  input  logic reset,
  fetch_controller_if.master bus
`ifdef FETCH_PERF_EN
  ,
  output logic [15:0] perf_fetch,
  output logic [15:0] perf_flush,
  output logic [15:0] perf_stall
`endif
);
  localparam logic [31:0] PC_MAX = 32'(MEM_BYTES - 4);
  fetch_state_e state;
  logic [31:0] pc, pc4, next_pc, ifid_instr, ifid_pc4;
  logic ifid_valid, halted, run, redirect, load, flush;
  always_comb begin
    run      = state == S_RUN;
    redirect = run & (bus.branch_taken | bus.jump);
    load     = run & ~redirect & ~bus.stall;
    flush    = ~run | redirect;
    pc4      = pc + 32'd4;
    next_pc  = bus.branch_taken ? (bus.branch_target & ~32'd3) :
               bus.jump ? {ifid_pc4[31:28], bus.jump_index, 2'b00} :
               bus.stall ? pc : pc4;
  end
  // Out-of-range next PC is still taken, so imem_pc shows where fetch stopped
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state  <= S_INIT;
      pc     <= RESET_PC;
      halted <= 1'b0;
    end else if (state == S_INIT) begin
      state <= S_RUN;
    end else if (run) begin
      pc <= next_pc;
      if (next_pc > PC_MAX) begin
        state  <= S_HALT;
        halted <= 1'b1;
      end
    end
  end
  if_id_reg u_if_id (
    .clk     (clk),
    .reset   (reset),
    .load    (load),
    .flush   (flush),
    .instr_d (bus.imem_instr),
    .pc4_d   (pc4),
    .instr   (ifid_instr),
    .pc4     (ifid_pc4),
    .valid   (ifid_valid)
  );
  assign bus.imem_pc    = pc;
  assign bus.ifid_instr = ifid_instr;
  assign bus.ifid_pc4   = ifid_pc4;
  assign bus.ifid_valid = ifid_valid;
  assign bus.halted     = halted;
`ifdef FETCH_PERF_EN
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      perf_fetch <= '0;
      perf_flush <= '0;
      perf_stall <= '0;
    end else begin
      if (load) perf_fetch <= sat_inc(perf_fetch);
      if (redirect) perf_flush <= sat_inc(perf_flush);
      if (run & bus.stall & ~redirect) perf_stall <= sat_inc(perf_stall);
    end
  end
`endif
endmodule

// File: tb/tb_fetch_controller.sv
// tb_fetch_controller: directed stimulus with a per-cycle behavioural model and literal spot checks
module tb_fetch_controller;
  localparam int MB = 72;
  logic clk = 1'b0;
  logic reset = 1'b1;
  logic cmp_en = 1'b0;
  int checks = 0;
  int errors = 0;
  logic [31:0] mem [MB/4];
  always #5 clk = ~clk;
  fetch_controller_if bus();
  function automatic logic [31:0] word_at(input logic [31:0] a);
    return (a <= 32'(MB - 4)) ? mem[int'(a >> 2)] : 32'h0;
  endfunction
  assign bus.imem_instr = word_at(bus.imem_pc);
`ifdef FETCH_PERF_EN
  logic [15:0] pf, pfl, ps;
`endif
  fetch_controller #(.MEM_BYTES(MB), .RESET_PC(32'h0)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
`ifdef FETCH_PERF_EN
    ,
    .perf_fetch (pf),
    .perf_flush (pfl),
    .perf_stall (ps)
`endif
  );
  int phase;
  logic [31:0] m_pc, m_instr, m_pc4, t;
  logic m_valid, m_halt;
  int m_fetch, m_flush, m_stall;
  always @(posedge clk or negedge reset) begin
    if (!reset) begin
      phase = 0; m_pc = 0; m_instr = 0; m_pc4 = 0; m_valid = 0; m_halt = 0;
      m_fetch = 0; m_flush = 0; m_stall = 0;
    end else if (phase == 0) begin
      phase = 1;
    end else if (phase == 1) begin
      if (bus.branch_taken || bus.jump) begin
        t = bus.branch_taken ? (bus.branch_target / 4) * 4 : {m_pc4[31:28], bus.jump_index, 2'b00};
        m_instr = 0; m_valid = 0; m_flush++;
      end else if (bus.stall) begin
        t = m_pc; m_stall++;
      end else begin
        m_instr = word_at(m_pc); m_pc4 = m_pc + 4; m_valid = 1; t = m_pc + 4; m_fetch++;
      end
      m_pc = t;
      if (t > MB - 4) begin phase = 2; m_halt = 1; end
    end else begin
      m_instr = 0; m_valid = 0;
    end
  end
  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h expected=%h at %0t", name, act, exp, $time);
    end
  endtask
  always @(negedge clk) if (cmp_en) begin
    chk("model imem_pc", bus.imem_pc, m_pc);
    chk("model ifid_instr", bus.ifid_instr, m_instr);
    chk("model ifid_pc4", bus.ifid_pc4, m_pc4);
    chk("model ifid_valid", 32'(bus.ifid_valid), 32'(m_valid));
    chk("model halted", 32'(bus.halted), 32'(m_halt));
`ifdef FETCH_PERF_EN
    chk("model perf_fetch", 32'(pf), 32'(m_fetch));
    chk("model perf_flush", 32'(pfl), 32'(m_flush));
    chk("model perf_stall", 32'(ps), 32'(m_stall));
`endif
  end
  task automatic cyc();
    @(negedge clk);
    #1;
  endtask
  initial begin
    for (int i = 0; i < MB / 4; i++) mem[i] = 32'h2000_0000 + 32'(i);
    mem[0] = 32'h0800_0005;
    bus.stall = 0; bus.jump = 0; bus.jump_index = 0; bus.branch_taken = 0; bus.branch_target = 0;
    #1 reset = 1'b0;
    repeat (2) @(negedge clk);
    reset = 1'b1;
    cmp_en = 1'b1;
    cyc();
    chk("init imem_pc", bus.imem_pc, 32'h0);
    chk("init valid", 32'(bus.ifid_valid), 32'h0);
    cyc();
    chk("fetch0 instr", bus.ifid_instr, 32'h0800_0005);
    chk("fetch0 pc4", bus.ifid_pc4, 32'h4);
    chk("fetch0 imem_pc", bus.imem_pc, 32'h4);
    bus.jump = 1; bus.jump_index = 26'd5;
    cyc();
    bus.jump = 0;
    chk("jump imem_pc", bus.imem_pc, 32'd20);
    chk("jump flush valid", 32'(bus.ifid_valid), 32'h0);
    chk("jump flush instr", bus.ifid_instr, 32'h0);
    cyc();
    chk("target instr", bus.ifid_instr, 32'h2000_0005);
    chk("target pc4", bus.ifid_pc4, 32'd24);
    for (int i = 0; i < 20 && bus.imem_pc != 32'd40; i++) cyc();
    chk("reach pc40", bus.imem_pc, 32'd40);
    bus.stall = 1;
    for (int i = 0; i < 2; i++) begin
      cyc();
      chk("stall imem_pc", bus.imem_pc, 32'd40);
      chk("stall pc4", bus.ifid_pc4, 32'd40);
      chk("stall instr", bus.ifid_instr, 32'h2000_0009);
    end
    bus.stall = 0;
    cyc();
    chk("post stall pc4", bus.ifid_pc4, 32'd44);
    chk("post stall instr", bus.ifid_instr, 32'h2000_000A);
    bus.stall = 1; bus.branch_taken = 1; bus.branch_target = 32'h43;
    cyc();
    bus.stall = 0; bus.branch_taken = 0; bus.branch_target = 0;
    chk("branch imem_pc", bus.imem_pc, 32'd64);
    chk("branch flush valid", 32'(bus.ifid_valid), 32'h0);
    cyc();
    chk("pre-halt imem_pc", bus.imem_pc, 32'd68);
    chk("pre-halt halted", 32'(bus.halted), 32'h0);
    cyc();
    chk("last instr", bus.ifid_instr, 32'h2000_0011);
    chk("last pc4", bus.ifid_pc4, 32'd72);
    chk("last valid", 32'(bus.ifid_valid), 32'h1);
    chk("halt imem_pc", bus.imem_pc, 32'd72);
    chk("halted", 32'(bus.halted), 32'h1);
    cyc();
    chk("halt nop valid", 32'(bus.ifid_valid), 32'h0);
    chk("halt nop instr", bus.ifid_instr, 32'h0);
    bus.branch_taken = 1;
    cyc();
    cyc();
    bus.branch_taken = 0;
    chk("halt ignores branch", bus.imem_pc, 32'd72);
    chk("halt stays", 32'(bus.halted), 32'h1);
    reset = 1'b0;
    #1;
    chk("reset from halt", 32'(bus.halted), 32'h0);
    @(negedge clk);
    reset = 1'b1;
    repeat (5) cyc();
    bus.stall = 1;
    cyc();
    @(posedge clk);
    #2 reset = 1'b0;
    #1;
    chk("async imem_pc", bus.imem_pc, 32'h0);
    chk("async instr", bus.ifid_instr, 32'h0);
    chk("async pc4", bus.ifid_pc4, 32'h0);
    chk("async valid", 32'(bus.ifid_valid), 32'h0);
    chk("async halted", 32'(bus.halted), 32'h0);
`ifdef FETCH_PERF_EN
    chk("async perf_fetch", 32'(pf), 32'h0);
    chk("async perf_flush", 32'(pfl), 32'h0);
    chk("async perf_stall", 32'(ps), 32'h0);
`endif
    bus.stall = 0;
    @(negedge clk);
    reset = 1'b1;
    repeat (3) cyc();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
